writeback_stage: RTL
====================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage, directly downstream of mem_stage; consumes its rd/opcode/funct3/load-data outputs.
//  Load path: selects the byte/half/word from the raw 32-bit load word, then sign- or zero-extends it.
//  Non-load path: passes the ALU result through. Commits a registered register-file write (addr/data/we).
//  Keeps a retired-instruction counter and flags misaligned loads.
// PARAMETERS
//  DWIDTH       32  data width (must be 32: byte lanes are fixed)
//  AWIDTH       5   register address width
//  FUNCT_WIDTH  3   funct3 width
//  CNT_WIDTH    32  retired-instruction counter width
// PORTS
//  wb_clk          in   1               clock, rising edge
//  wb_rst          in   1               asynchronous, active-low reset
//  wb_i_ce         in   1               valid instruction from mem_stage
//  wb_i_stall      in   1               hold: no state change, no commit
//  wb_i_flush      in   1               kill the instruction presented this cycle
//  wb_i_opcode     in   `OPCODE_WIDTH   one-hot opcode (`LOAD_WORD, `RTYPE, ... bit indices)
//  wb_i_funct3     in   FUNCT_WIDTH     load width/sign (`FUNCT_LB/LH/LW/LBU/LHU)
//  wb_i_byte_off   in   2               address[1:0] of the load
//  wb_i_load_data  in   DWIDTH          raw aligned word read from memory
//  wb_i_rd_addr    in   AWIDTH          destination register
//  wb_i_rd_data    in   DWIDTH          ALU/result value for non-load instructions
//  wb_i_rd_we      in   1               instruction writes rd
//  wb_o_rd_addr    out  AWIDTH          register-file write address (registered)
//  wb_o_rd_data    out  DWIDTH          register-file write data (registered)
//  wb_o_rd_we      out  1               register-file write strobe, one cycle per commit
//  wb_o_misaligned out  1               one-cycle pulse: the load was dropped as misaligned
//  wb_o_retired    out  CNT_WIDTH       count of committed instructions
//  wb_o_stall      out  1               = wb_i_stall (combinational, returned upstream)
// BEHAVIOUR
//  Reset (wb_rst=0, async): all outputs and all registers 0.
//  accept = wb_i_ce & ~wb_i_stall & ~wb_i_flush. Latency: accept at edge N -> outputs valid after edge N.
//  Stall: all registers hold, except wb_o_rd_we and wb_o_misaligned, which clear to 0
//    (no duplicate writes, single-cycle pulses).
//  Flush: the presented instruction is dropped; rd_we=0; counter unchanged. Flush wins over ce.
//  Not accepted and not stalled: rd_we=0, misaligned=0; rd_addr/rd_data hold.
//  Load (opcode[`LOAD_WORD]), sel = wb_i_load_data >> (8*byte_off):
//    LB  -> {{24{sel[7]}},sel[7:0]}      LBU -> {24'b0,sel[7:0]}     any offset is legal
//    LH  -> {{16{sel[15]}},sel[15:0]}    LHU -> zero-extended        offset 0..2 legal; 3 is misaligned
//    LW  -> word                         offset 0 only
//    Any other funct3 is treated as misaligned.
//  Misaligned load: no write (rd_we=0), misaligned=1 for one cycle, counter still increments.
//  Non-load: rd_data <= wb_i_rd_data.
//  rd_we <= accept & wb_i_rd_we & (wb_i_rd_addr != 0) & ~misaligned. x0 is never written; still retired.
//  wb_o_retired += 1 on every accept, wraps modulo 2^CNT_WIDTH.
//  Simultaneous stall+flush: stall dominates, so the instruction is held and not killed.
//  Reset asserted mid-commit clears rd_we immediately.
// STRUCTURE
//  Shared header (existing defines): `OPCODE_WIDTH, opcode bit indices, `FUNCT_* codes; nothing new added.
//  Sub-module load_extend (combinational: funct3, byte_off, word -> data, misaligned) is natural.
//  The top level holds the registers, the commit logic and the counter.
// TESTING
//  1 Reset: hold wb_rst=0 for 2 cycles with ce=1 -> all outputs 0, retired=0.
//  2 Load word=32'h8899AABB:
//      LB  off1 -> rd_data FFFFFFAA
//      LBU off3 -> 00000088
//      LH  off2 -> FFFF8899
//      LHU off0 -> 0000AABB
//      LW  off0 -> 8899AABB
//    rd_we=1 for exactly one cycle each.
//  3 Misaligned: LW off2, then LH off3 -> rd_we=0 and misaligned=1 for one cycle each; retired +2.
//  4 RTYPE rd=5, data=32'h12345678 -> after one edge: rd_addr=5, rd_data=12345678, we=1.
//    Same instruction with rd=0 -> we=0, retired increments.
//  5 Stall 3 cycles with ce=1 -> no writes and retired unchanged during the stall;
//    exactly one commit after release.
//  6 Flush with ce=1 -> no write, retired unchanged.
//    Stall+flush together -> held, then committed after the stall clears.
//    Counter preloaded to all-ones + 1 accept -> wraps to 0.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - opcode indices, funct3 load codes and load result type
package writeback_stage_pkg;

  localparam int OPCODE_WIDTH = 11;

  // One-hot opcode bit indices shared with the upstream pipeline stages
  localparam int RTYPE      = 0;
  localparam int ITYPE      = 1;
  localparam int LOAD_WORD  = 2;
  localparam int STORE_WORD = 3;
  localparam int BRANCH     = 4;
  localparam int JAL        = 5;
  localparam int JALR       = 6;
  localparam int LUI        = 7;
  localparam int AUIPC      = 8;
  localparam int SYSTEM     = 9;
  localparam int FENCE      = 10;

  localparam logic [2:0] FUNCT_LB  = 3'b000;
  localparam logic [2:0] FUNCT_LH  = 3'b001;
  localparam logic [2:0] FUNCT_LW  = 3'b010;
  localparam logic [2:0] FUNCT_LBU = 3'b100;
  localparam logic [2:0] FUNCT_LHU = 3'b101;

  typedef struct packed {
    logic [31:0] data;
    logic        misaligned;
  } load_result_t;

endpackage

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - mem_stage to writeback_stage bus and register-file commit outputs
interface writeback_if
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int CNT_WIDTH   = 32
) ();

  logic                    wb_i_ce;
  logic                    wb_i_stall;
  logic                    wb_i_flush;
  logic [OPCODE_WIDTH-1:0] wb_i_opcode;
  logic [FUNCT_WIDTH-1:0]  wb_i_funct3;
  logic [1:0]              wb_i_byte_off;
  logic [DWIDTH-1:0]       wb_i_load_data;
  logic [AWIDTH-1:0]       wb_i_rd_addr;
  logic [DWIDTH-1:0]       wb_i_rd_data;
  logic                    wb_i_rd_we;
  logic [AWIDTH-1:0]       wb_o_rd_addr;
  logic [DWIDTH-1:0]       wb_o_rd_data;
  logic                    wb_o_rd_we;
  logic                    wb_o_misaligned;
  logic [CNT_WIDTH-1:0]    wb_o_retired;
  logic                    wb_o_stall;

  modport master (
    output wb_i_ce, wb_i_stall, wb_i_flush, wb_i_opcode, wb_i_funct3, wb_i_byte_off,
           wb_i_load_data, wb_i_rd_addr, wb_i_rd_data, wb_i_rd_we,
    input  wb_o_rd_addr, wb_o_rd_data, wb_o_rd_we, wb_o_misaligned, wb_o_retired, wb_o_stall
  );

  modport slave (
    input  wb_i_ce, wb_i_stall, wb_i_flush, wb_i_opcode, wb_i_funct3, wb_i_byte_off,
           wb_i_load_data, wb_i_rd_addr, wb_i_rd_data, wb_i_rd_we,
    output wb_o_rd_addr, wb_o_rd_data, wb_o_rd_we, wb_o_misaligned, wb_o_retired, wb_o_stall
  );

endinterface

// File: rtl/writeback_stage_load_extend.sv
// rtl/writeback_stage_load_extend.sv - byte/half/word lane select with sign or zero extension
module writeback_stage_load_extend
  import writeback_stage_pkg::*;
(
  input  logic [2:0]   funct3_i,
  input  logic [1:0]   byte_off_i,
  input  logic [31:0]  word_i,
  output load_result_t result_o
);

  logic [31:0] sel;

  assign sel = word_i >> {byte_off_i, 3'b000};

  always_comb begin
    result_o = '0;
    unique case (funct3_i)
      FUNCT_LB:  result_o.data = {{24{sel[7]}}, sel[7:0]};
      FUNCT_LBU: result_o.data = {24'b0, sel[7:0]};
      FUNCT_LH: begin
        result_o.data       = {{16{sel[15]}}, sel[15:0]};
        result_o.misaligned = (byte_off_i == 2'd3);
      end
      FUNCT_LHU: begin
        result_o.data       = {16'b0, sel[15:0]};
        result_o.misaligned = (byte_off_i == 2'd3);
      end
      FUNCT_LW: begin
        result_o.data       = word_i;
        result_o.misaligned = (byte_off_i != 2'd0);
      end
      // Reserved load encodings are dropped the same way as a misaligned access
      default: result_o.misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - final pipeline stage: load extension, register-file commit, retire counter
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int CNT_WIDTH   = 32
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  writeback_if.slave  wb
);

  logic                 accept;
  logic                 is_load;
  logic                 misaligned;
  load_result_t         ld_res;
  logic                 unused_opcode_bits;

  logic [AWIDTH-1:0]    rd_addr_d, rd_addr_q;
  logic [DWIDTH-1:0]    rd_data_d, rd_data_q;
  logic                 rd_we_d, rd_we_q;
  logic                 mis_d, mis_q;
  logic [CNT_WIDTH-1:0] retired_d, retired_q;

  writeback_stage_load_extend u_load_extend (
    .funct3_i   (wb.wb_i_funct3),
    .byte_off_i (wb.wb_i_byte_off),
    .word_i     (wb.wb_i_load_data),
    .result_o   (ld_res)
  );

  assign accept     = wb.wb_i_ce & ~wb.wb_i_stall & ~wb.wb_i_flush;
  assign is_load    = wb.wb_i_opcode[LOAD_WORD];
  assign misaligned = is_load & ld_res.misaligned;
  assign unused_opcode_bits = ^{wb.wb_i_opcode[OPCODE_WIDTH-1:LOAD_WORD+1],
                                wb.wb_i_opcode[LOAD_WORD-1:0]};

  // Stall freezes everything except the strobes, which drop so a held
  // instruction never produces a second write or a stretched pulse.
  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    retired_d = retired_q;
    rd_we_d   = 1'b0;
    mis_d     = 1'b0;
    if (!wb.wb_i_stall && accept) begin
      rd_addr_d = wb.wb_i_rd_addr;
      rd_data_d = is_load ? ld_res.data : wb.wb_i_rd_data;
      rd_we_d   = wb.wb_i_rd_we & (wb.wb_i_rd_addr != '0) & ~misaligned;
      mis_d     = misaligned;
      retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_we_q   <= 1'b0;
      mis_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      rd_we_q   <= rd_we_d;
      mis_q     <= mis_d;
      retired_q <= retired_d;
    end
  end

  assign wb.wb_o_rd_addr    = rd_addr_q;
  assign wb.wb_o_rd_data    = rd_data_q;
  assign wb.wb_o_rd_we      = rd_we_q;
  assign wb.wb_o_misaligned = mis_q;
  assign wb.wb_o_retired    = retired_q;
  assign wb.wb_o_stall      = wb.wb_i_stall;

endmodule
